// File: rtl/fetch_decode_queue_pkg.sv
// Purpose: shared sizing constants and entry record layout for the fetch/decode queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_decode_queue_pkg;

    localparam int addressWidth            = 64;
    localparam int instructionWidth        = 32;
    localparam int PidSize                 = 20;
    localparam int TidSize                 = 16;
    localparam int instructionCounterWidth = 64;
    localparam int fetchWidth              = 4;
    localparam int decodeWidth             = 2;
    localparam int queueDepth              = 16;  // power of 2, >= fetchWidth + decodeWidth

    localparam int ptrWidth      = $clog2(queueDepth);
    localparam int countWidth    = ptrWidth + 1;       // holds 0..queueDepth inclusive
    localparam int enqCountWidth = $clog2(fetchWidth) + 1;

    // One queued instruction; field order fixes the bit offsets inside the RAM word.
    typedef struct packed {
        logic [instructionWidth-1:0]        instruction;
        logic [addressWidth-1:0]            address;
        logic [instructionCounterWidth-1:0] majId;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic                               is64Bit;
    } fdqEntry_t;

    localparam int entryWidth = $bits(fdqEntry_t);

endpackage

// File: rtl/fdq_entry_ram.sv
// Purpose: queueDepth-entry register array, fetchWidth write ports, decodeWidth read ports.
// Latency: writes land at the clock edge; reads are combinational from the addresses.
// Backpressure: none; the caller guarantees distinct write addresses per cycle.
// Ports: clock_i; wrEn/wrAddr/wrData per write lane; rdAddr/rdData per read lane.
// Storage is deliberately reset-free; validity is tracked by the owner's pointers.
module fdq_entry_ram
    import fetch_decode_queue_pkg::*;
(
    input  logic                                clock_i,
    input  logic [fetchWidth-1:0]               wrEn,
    input  logic [fetchWidth*ptrWidth-1:0]      wrAddr,
    input  logic [fetchWidth*entryWidth-1:0]    wrData,
    input  logic [decodeWidth*ptrWidth-1:0]     rdAddr,
    output logic [decodeWidth*entryWidth-1:0]   rdData
);

    logic [entryWidth-1:0] mem [queueDepth];

    always_ff @(posedge clock_i) begin
        for (int k = 0; k < fetchWidth; k++) begin
            if (wrEn[k]) begin
                mem[wrAddr[k*ptrWidth +: ptrWidth]] <= wrData[k*entryWidth +: entryWidth];
            end
        end
    end

    for (genvar j = 0; j < decodeWidth; j++) begin : gRd
        assign rdData[j*entryWidth +: entryWidth] = mem[rdAddr[j*ptrWidth +: ptrWidth]];
    end

endmodule

// File: rtl/fetch_decode_queue.sv
// Purpose: multi-lane instruction queue from fetch to decode with in-block major ID tagging.
// Latency: 2 edges enqueue-to-output (no bypass); outputs registered.
// Backpressure: ready_o drops when a full bundle no longer fits; stall_i freezes decode lanes.
// Ports: fetch side enable_i/enqCount_i/instructions_i (lane 0 at MSB)/baseAddress_i/is64Bit_i/
//        pid_i/tid_i, ready_o; decode side stall_i, valid_o and per-lane fields (lane 0 at LSB,
//        oldest); flush_i clears the queue; reset_i async active-low.
// Optional: FDQ_PERF_COUNTERS_EN adds fullCycles_o / emptyCycles_o saturating counters.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
(
    input  logic                                        clock_i,
    input  logic                                        reset_i,
    input  logic                                        enable_i,
    input  logic [enqCountWidth-1:0]                    enqCount_i,
    input  logic [fetchWidth*instructionWidth-1:0]      instructions_i,
    input  logic [addressWidth-1:0]                     baseAddress_i,
    input  logic                                        is64Bit_i,
    input  logic [PidSize-1:0]                          pid_i,
    input  logic [TidSize-1:0]                          tid_i,
    input  logic                                        stall_i,
    input  logic                                        flush_i,
    output logic                                        ready_o,
    output logic [decodeWidth-1:0]                      valid_o,
    output logic [decodeWidth*instructionWidth-1:0]     instructions_o,
    output logic [decodeWidth*addressWidth-1:0]         addresses_o,
    output logic [decodeWidth*instructionCounterWidth-1:0] majIds_o,
    output logic [decodeWidth-1:0]                      is64Bit_o,
    output logic [decodeWidth*PidSize-1:0]              pids_o,
    output logic [decodeWidth*TidSize-1:0]              tids_o
`ifdef FDQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]                                 fullCycles_o,
    output logic [31:0]                                 emptyCycles_o
`endif
);

    logic [ptrWidth-1:0]                head;
    logic [ptrWidth-1:0]                tail;
    logic [countWidth-1:0]              count;
    logic [instructionCounterWidth-1:0] nextMajId;

    logic [enqCountWidth-1:0] enqSat;
    logic                     accept;
    logic [countWidth-1:0]    nAcc;
    logic [countWidth-1:0]    nDeq;

    // Only the registered count feeds ready_o, so it never depends on this cycle's inputs.
    assign ready_o = (countWidth'(queueDepth) - count) >= countWidth'(fetchWidth);

    assign enqSat = (enqCount_i > enqCountWidth'(fetchWidth)) ? enqCountWidth'(fetchWidth)
                                                              : enqCount_i;
    // A flush wins over a same-cycle enqueue: the bundle is discarded.
    assign accept = enable_i && ready_o && (enqCount_i != '0) && !flush_i;
    assign nAcc   = accept ? countWidth'(enqSat) : '0;
    assign nDeq   = stall_i ? '0
                  : ((count > countWidth'(decodeWidth)) ? countWidth'(decodeWidth) : count);

    logic [fetchWidth-1:0]              wrEn;
    logic [fetchWidth*ptrWidth-1:0]     wrAddr;
    logic [fetchWidth*entryWidth-1:0]   wrData;
    logic [decodeWidth*ptrWidth-1:0]    rdAddr;
    logic [decodeWidth*entryWidth-1:0]  rdData;
    fdqEntry_t                          rdEnt [decodeWidth];

    for (genvar k = 0; k < fetchWidth; k++) begin : gWr
        fdqEntry_t wrEnt;
        assign wrEnt = '{
            instruction: instructions_i[(fetchWidth-1-k)*instructionWidth +: instructionWidth],
            address:     baseAddress_i + addressWidth'(4*k),
            majId:       nextMajId + instructionCounterWidth'(k),
            pid:         pid_i,
            tid:         tid_i,
            is64Bit:     is64Bit_i
        };
        assign wrEn[k]                             = accept && (enqCountWidth'(k) < enqSat);
        assign wrAddr[k*ptrWidth +: ptrWidth]      = tail + ptrWidth'(k);  // wraps modulo depth
        assign wrData[k*entryWidth +: entryWidth]  = wrEnt;
    end

    for (genvar j = 0; j < decodeWidth; j++) begin : gRd
        assign rdAddr[j*ptrWidth +: ptrWidth] = head + ptrWidth'(j);
        assign rdEnt[j]                       = rdData[j*entryWidth +: entryWidth];
    end

    fdq_entry_ram uRam (
        .clock_i (clock_i),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .rdAddr  (rdAddr),
        .rdData  (rdData)
    );

    // Pointers, occupancy and ID generator. nextMajId survives flush so IDs stay unique.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            nextMajId <= '0;
        end else if (flush_i) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            head      <= head + ptrWidth'(nDeq);
            tail      <= tail + ptrWidth'(nAcc);
            count     <= count + nAcc - nDeq;
            nextMajId <= nextMajId + instructionCounterWidth'(nAcc);
        end
    end

    // Decode lane registers: reload every unstalled cycle, hold while stalled.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_o        <= '0;
            instructions_o <= '0;
            addresses_o    <= '0;
            majIds_o       <= '0;
            is64Bit_o      <= '0;
            pids_o         <= '0;
            tids_o         <= '0;
        end else if (flush_i) begin
            valid_o <= '0;
        end else if (!stall_i) begin
            for (int j = 0; j < decodeWidth; j++) begin
                valid_o[j] <= countWidth'(j) < count;
                instructions_o[j*instructionWidth +: instructionWidth]       <= rdEnt[j].instruction;
                addresses_o[j*addressWidth +: addressWidth]                  <= rdEnt[j].address;
                majIds_o[j*instructionCounterWidth +: instructionCounterWidth] <= rdEnt[j].majId;
                is64Bit_o[j]                                                 <= rdEnt[j].is64Bit;
                pids_o[j*PidSize +: PidSize]                                 <= rdEnt[j].pid;
                tids_o[j*TidSize +: TidSize]                                 <= rdEnt[j].tid;
            end
        end
    end

`ifdef FDQ_PERF_COUNTERS_EN
    // Saturating event counters; cleared only by reset.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            fullCycles_o  <= '0;
            emptyCycles_o <= '0;
        end else begin
            if (enable_i && !ready_o && (fullCycles_o != '1)) begin
                fullCycles_o <= fullCycles_o + 32'd1;
            end
            if ((count == '0) && !stall_i && (emptyCycles_o != '1)) begin
                emptyCycles_o <= emptyCycles_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Purpose: self-checking bench for fetch_decode_queue using a reference queue scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_decode_queue;

    logic         clock = 1'b0;
    logic         reset_i = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   enqCount = '0;
    logic [127:0] instructions = '0;
    logic [63:0]  baseAddress = '0;
    logic         is64 = 1'b0;
    logic [19:0]  pid = '0;
    logic [15:0]  tid = '0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;

    logic         ready;
    logic [1:0]   validO;
    logic [63:0]  instrO;
    logic [127:0] addrO;
    logic [127:0] majO;
    logic [1:0]   is64O;
    logic [39:0]  pidO;
    logic [31:0]  tidO;

    always #5 clock = ~clock;

    fetch_decode_queue dut (
        .clock_i        (clock),
        .reset_i        (reset_i),
        .enable_i       (enable),
        .enqCount_i     (enqCount),
        .instructions_i (instructions),
        .baseAddress_i  (baseAddress),
        .is64Bit_i      (is64),
        .pid_i          (pid),
        .tid_i          (tid),
        .stall_i        (stall),
        .flush_i        (flush),
        .ready_o        (ready),
        .valid_o        (validO),
        .instructions_o (instrO),
        .addresses_o    (addrO),
        .majIds_o       (majO),
        .is64Bit_o      (is64O),
        .pids_o         (pidO),
        .tids_o         (tidO)
    );

    typedef struct {
        logic [31:0] ins;
        logic [63:0] addr;
        logic [63:0] maj;
        logic [19:0] pid;
        logic [15:0] tid;
        logic        m64;
    } ent_t;

    ent_t        mq[$];
    ent_t        expLane [2];
    logic [1:0]  expValid = '0;
    logic [63:0] nextMaj = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: advances on the same edge as the DUT, using last negedge's inputs.
    always @(posedge clock) begin
        int   oldSize;
        int   n;
        ent_t e;
        if (reset_i) begin
            oldSize = mq.size();
            if (flush) begin
                mq.delete();
                expValid = '0;
            end else begin
                if (!stall) begin
                    for (int j = 0; j < 2; j++) begin
                        if (mq.size() > 0) begin
                            expLane[j]  = mq.pop_front();
                            expValid[j] = 1'b1;
                        end else begin
                            expValid[j] = 1'b0;
                        end
                    end
                end
                if (enable && (16 - oldSize) >= 4 && enqCount != 0) begin
                    n = (enqCount > 4) ? 4 : int'(enqCount);
                    for (int k = 0; k < n; k++) begin
                        e.ins  = instructions[(3-k)*32 +: 32];
                        e.addr = baseAddress + 64'(4*k);
                        e.maj  = nextMaj + 64'(k);
                        e.pid  = pid;
                        e.tid  = tid;
                        e.m64  = is64;
                        mq.push_back(e);
                    end
                    nextMaj = nextMaj + 64'(n);
                end
            end
        end
    end

    // Scoreboard compare of every decode lane the model says is valid.
    always @(negedge clock) begin
        if (reset_i) begin
            checkVal("valid", 64'(validO), 64'(expValid));
            checkVal("ready", 64'(ready), 64'(mq.size() <= 12));
            for (int j = 0; j < 2; j++) begin
                if (expValid[j] && validO[j]) begin
                    checkVal($sformatf("majId%0d", j), majO[j*64 +: 64], expLane[j].maj);
                    checkVal($sformatf("addr%0d", j), addrO[j*64 +: 64], expLane[j].addr);
                    checkVal($sformatf("instr%0d", j), 64'(instrO[j*32 +: 32]), 64'(expLane[j].ins));
                    checkVal($sformatf("pid%0d", j), 64'(pidO[j*20 +: 20]), 64'(expLane[j].pid));
                    checkVal($sformatf("tid%0d", j), 64'(tidO[j*16 +: 16]), 64'(expLane[j].tid));
                    checkVal($sformatf("is64_%0d", j), 64'(is64O[j]), 64'(expLane[j].m64));
                end
            end
        end
    end

    task automatic cyc(input bit en, input int n, input logic [63:0] base, input bit st, input bit fl);
        enable       = en;
        enqCount     = 3'(n);
        instructions = {$urandom, $urandom, $urandom, $urandom};
        baseAddress  = base;
        is64         = 1'($urandom);
        pid          = 20'($urandom);
        tid          = 16'($urandom);
        stall        = st;
        flush        = fl;
        @(negedge clock);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cyc(0, 0, 64'h0, 0, 0);
    endtask

    function automatic logic [63:0] rndBase();
        return {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
    endfunction

    task automatic checkZero(input string tag);
        checkVal({tag, "_valid"}, 64'(validO), 64'h0);
        checkVal({tag, "_maj"}, 64'(majO != '0), 64'h0);
        checkVal({tag, "_addr"}, 64'(addrO != '0), 64'h0);
        checkVal({tag, "_instr"}, 64'(instrO != '0), 64'h0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic doReset();
        enable = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clock);
        #2 reset_i = 1'b0;
        #1 checkZero("asyncRst");
        mq.delete();
        expValid = '0;
        nextMaj  = '0;
        @(negedge clock);
        @(negedge clock);
        checkVal("rstReady", 64'(ready), 64'h1);
        reset_i = 1'b1;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        checkZero("rst");
        checkVal("rstReady", 64'(ready), 64'h1);
        reset_i = 1'b1;

        // First bundle: two lanes per cycle, 2-edge latency
        cyc(1, 4, 64'h1000, 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        checkVal("t1_valid", 64'(validO), 64'h3);
        checkVal("t1_addr0", addrO[63:0], 64'h1000);
        checkVal("t1_addr1", addrO[127:64], 64'h1004);
        checkVal("t1_maj0", majO[63:0], 64'd0);
        checkVal("t1_maj1", majO[127:64], 64'd1);
        cyc(0, 0, 64'h0, 0, 0);
        checkVal("t1_addr2", addrO[63:0], 64'h1008);
        checkVal("t1_addr3", addrO[127:64], 64'h100C);
        checkVal("t1_maj2", majO[63:0], 64'd2);
        checkVal("t1_maj3", majO[127:64], 64'd3);
        idle(2);

        // Fill while stalled; fifth request must be dropped
        for (int b = 0; b < 5; b++) cyc(1, 4, rndBase(), 1, 0);
        checkVal("fullReady", 64'(ready), 64'h0);
        idle(10);

        // Partial bundles, saturation, single leftover
        cyc(1, 3, rndBase(), 1, 0);
        cyc(1, 1, rndBase(), 1, 0);
        idle(3);
        cyc(1, 3, rndBase(), 0, 0);
        idle(3);
        cyc(1, 7, rndBase(), 0, 0);
        idle(3);

        // Continuous traffic across pointer wrap
        for (int i = 0; i < 20; i++) cyc(1, 2, rndBase(), 0, 0);
        idle(3);

        // Stall hold with valid lanes
        cyc(1, 4, rndBase(), 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        cyc(0, 0, 64'h0, 1, 0);
        cyc(1, 2, rndBase(), 1, 0);
        idle(5);

        // Flush with same-cycle enqueue at count 6; IDs not rewound
        doReset();
        cyc(1, 4, rndBase(), 1, 0);
        cyc(1, 2, rndBase(), 1, 0);
        cyc(1, 4, rndBase(), 1, 1);
        checkVal("flushValid", 64'(validO), 64'h0);
        checkVal("flushReady", 64'(ready), 64'h1);
        cyc(1, 1, rndBase(), 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        checkVal("postFlushValid", 64'(validO), 64'h1);
        checkVal("postFlushMaj", majO[63:0], 64'd6);
        idle(2);

        // Mid-stream async reset, IDs restart at 0
        cyc(1, 4, rndBase(), 0, 0);
        cyc(1, 4, rndBase(), 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        doReset();
        cyc(1, 4, rndBase(), 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        checkVal("postRstMaj", majO[63:0], 64'd0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
